// File: rtl/spi_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : spi_arbiter
// Purpose : Round-robin arbiter sharing one SPI master between the RTC and
//           cart engines, with an inter-grant chip-select gap and an idle-clock
//           timeout that forcibly revokes a stalled grant.
// Rev     : 1.0  initial release
// ============================================================================
module spi_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GAP_CYCLES     = 2
) (
  input  logic       SClk,
  input  logic       Reset,
  input  logic [1:0] Req,
  output logic [1:0] Grant,
  input  logic [1:0] InClkRunning,
  input  logic [1:0] InClkStretch,
  input  logic [1:0] InSPIDo,
  input  logic [1:0] InnSel,
  output logic       OutClkRunning,
  output logic       OutClkStretch,
  output logic       OutSPIDo,
  output logic [1:0] OutnSel,
  output logic [1:0] Abort,
  output logic       TimeoutFlag,
  input  logic       ClearTimeout
);

  localparam int              CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [3:0]      GAP_LAST  = 4'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       abort_q, abort_d;
  logic [1:0]       blocked_q, blocked_d;
  logic             last_q, last_d;
  logic             flag_q, flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       gap_q, gap_d;

  logic             owner;
  logic [1:0]       eligible;
  logic             winner;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout;
  logic             in_grant;

  assign owner    = grant_q[1];
  assign in_grant = (state_q == GRANT);
  assign eligible = Req & ~blocked_q;
  // On a tie the requester that was not served last wins.
  assign winner   = (eligible == 2'b11) ? ~last_q : eligible[1];
  assign cnt_inc  = (cnt_q == CNT_LIMIT) ? cnt_q : cnt_q + CNT_W'(1);
  assign timeout  = in_grant && !InClkRunning[owner] && (cnt_inc == CNT_LIMIT);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    abort_d   = 2'b00;
    last_d    = last_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    blocked_d = blocked_q & Req;
    flag_d    = timeout | (flag_q & ~ClearTimeout);

    case (state_q)
      IDLE: begin
        if (|eligible) begin
          grant_d = winner ? 2'b10 : 2'b01;
          last_d  = winner;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Timeout takes precedence over a simultaneous request drop.
        if (timeout) begin
          abort_d   = grant_q;
          blocked_d = blocked_d | grant_q;
          grant_d   = 2'b00;
          cnt_d     = '0;
          gap_d     = '0;
          state_d   = GAP;
        end else if (!Req[owner]) begin
          grant_d = 2'b00;
          cnt_d   = '0;
          gap_d   = '0;
          state_d = GAP;
        end else if (InClkRunning[owner]) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      GAP: begin
        if (gap_q >= GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge SClk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      abort_q   <= 2'b00;
      blocked_q <= 2'b00;
      last_q    <= 1'b1;
      flag_q    <= 1'b0;
      cnt_q     <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      abort_q   <= abort_d;
      blocked_q <= blocked_d;
      last_q    <= last_d;
      flag_q    <= flag_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
    end
  end

  assign Grant         = grant_q;
  assign Abort         = abort_q;
  assign TimeoutFlag   = flag_q;
  assign OutClkRunning = in_grant & InClkRunning[owner];
  assign OutClkStretch = in_grant & InClkStretch[owner];
  assign OutSPIDo      = in_grant & InSPIDo[owner];
  assign OutnSel       = InnSel | ~grant_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_spi_arbiter
// Purpose : Directed plus randomized self-checking bench for spi_arbiter.
// Rev     : 1.0  initial release
// ============================================================================
module tb_spi_arbiter;

  localparam int TO  = 16;
  localparam int GAP = 2;

  logic       SClk = 1'b0;
  logic       Reset;
  logic [1:0] Req, Grant, InClkRunning, InClkStretch, InSPIDo, InnSel;
  logic [1:0] OutnSel, Abort;
  logic       OutClkRunning, OutClkStretch, OutSPIDo, TimeoutFlag, ClearTimeout;

  int errors = 0;
  int checks = 0;
  int n;
  int mode;

  // Reference model: who owns the bus, how long it has idled, remaining gap.
  int       m_owner;
  int       m_idle;
  int       m_gap;
  int       m_last;
  bit [1:0] m_blocked;
  bit [1:0] m_abort;
  bit       m_flag;

  spi_arbiter #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)) dut (
    .SClk(SClk), .Reset(Reset), .Req(Req), .Grant(Grant),
    .InClkRunning(InClkRunning), .InClkStretch(InClkStretch),
    .InSPIDo(InSPIDo), .InnSel(InnSel),
    .OutClkRunning(OutClkRunning), .OutClkStretch(OutClkStretch),
    .OutSPIDo(OutSPIDo), .OutnSel(OutnSel), .Abort(Abort),
    .TimeoutFlag(TimeoutFlag), .ClearTimeout(ClearTimeout)
  );

  always #5 SClk = ~SClk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_idle = 0; m_gap = 0; m_last = 1;
    m_blocked = 2'b00; m_abort = 2'b00; m_flag = 1'b0;
  endtask

  task automatic model_step();
    bit [1:0] nb;
    bit [1:0] el;
    bit       to;
    to = 1'b0;
    m_abort = 2'b00;
    nb = m_blocked & Req;
    if (m_owner >= 0) begin
      if (InClkRunning[m_owner]) m_idle = 0; else m_idle++;
      if (m_idle == TO) begin
        m_abort[m_owner] = 1'b1;
        nb[m_owner] = 1'b1;
        to = 1'b1;
        m_owner = -1;
        m_gap = GAP;
      end else if (!Req[m_owner]) begin
        m_owner = -1;
        m_gap = GAP;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      el = Req & ~m_blocked;
      if (el == 2'b11) m_owner = 1 - m_last;
      else if (el[0])  m_owner = 0;
      else if (el[1])  m_owner = 1;
      if (m_owner >= 0) begin
        m_last = m_owner;
        m_idle = 0;
      end
    end
    m_blocked = nb;
    if (to) m_flag = 1'b1;
    else if (ClearTimeout) m_flag = 1'b0;
  endtask

  task automatic check_all();
    logic [1:0] eg;
    logic er, es, ed;
    eg = (m_owner < 0) ? 2'b00 : (m_owner == 1) ? 2'b10 : 2'b01;
    er = (m_owner < 0) ? 1'b0 : InClkRunning[m_owner];
    es = (m_owner < 0) ? 1'b0 : InClkStretch[m_owner];
    ed = (m_owner < 0) ? 1'b0 : InSPIDo[m_owner];
    chk("grant", Grant, eg);
    chk("abort", Abort, m_abort);
    chk("flag", {1'b0, TimeoutFlag}, {1'b0, m_flag});
    chk("nsel", OutnSel, InnSel | ~eg);
    chk("clkrun", {1'b0, OutClkRunning}, {1'b0, er});
    chk("stretch", {1'b0, OutClkStretch}, {1'b0, es});
    chk("spido", {1'b0, OutSPIDo}, {1'b0, ed});
  endtask

  task automatic cycle();
    @(posedge SClk);
    model_step();
    @(negedge SClk);
    check_all();
  endtask

  // Reset asserted between edges; outputs must react before any clock edge.
  task automatic mid_reset();
    #2 Reset = 1'b1;
    #1;
    chk("rst_grant", Grant, 2'b00);
    chk("rst_nsel", OutnSel, 2'b11);
    chk("rst_abort", Abort, 2'b00);
    @(posedge SClk);
    @(negedge SClk);
    Reset = 1'b0;
    model_reset();
    check_all();
  endtask

  initial begin
    Reset = 1'b1; Req = 2'b00; InClkRunning = 2'b00; InClkStretch = 2'b00;
    InSPIDo = 2'b00; InnSel = 2'b00; ClearTimeout = 1'b0;
    model_reset();
    repeat (3) @(negedge SClk);
    Reset = 1'b0;
    check_all();
    chk("reset_nsel", OutnSel, 2'b11);

    // Single requester held 20 cycles then dropped.
    InClkRunning = 2'b01; Req = 2'b01;
    cycle();
    chk("r033_grant", Grant, 2'b01);
    repeat (19) begin
      cycle();
      chk("r033_nsel1", {1'b0, OutnSel[1]}, 2'b01);
    end
    Req = 2'b00;
    cycle();
    chk("r033_drop", Grant, 2'b00);
    repeat (GAP) cycle();

    // Tie from reset: requester 0 first, requester 1 after the gap.
    mid_reset();
    Req = 2'b11;
    cycle();
    chk("r034_first", Grant, 2'b01);
    repeat (3) cycle();
    Req = 2'b10;
    cycle();
    chk("r034_clear", Grant, 2'b00);
    n = 0;
    while (Grant !== 2'b10 && n < 20) begin
      cycle();
      n++;
    end
    chk_int("r034_gap", n, GAP + 1);
    Req = 2'b00;
    cycle();
    repeat (GAP) cycle();

    // Data mux follows requester 0 only.
    Req = 2'b01; InClkRunning = 2'b01;
    cycle();
    for (int i = 0; i < 8; i++) begin
      InSPIDo = {i[1], i[0]};
      InClkStretch = {i[0], i[1]};
      cycle();
      chk("r035_do", {1'b0, OutSPIDo}, {1'b0, i[0]});
    end
    Req = 2'b00;
    cycle();
    repeat (GAP) cycle();

    // Requester 1 stalls with no clock -> timeout.
    Req = 2'b10; InClkRunning = 2'b00;
    cycle();
    chk("r036_grant", Grant, 2'b10);
    n = 0;
    while (Abort === 2'b00 && n < 40) begin
      cycle();
      n++;
    end
    chk_int("r036_cycles", n, TO);
    chk("r036_abort", Abort, 2'b10);
    chk("r036_flag", {1'b0, TimeoutFlag}, 2'b01);
    chk("r036_grant0", Grant, 2'b00);
    repeat (10) begin
      cycle();
      chk("r036_noregrant", Grant, 2'b00);
    end

    // Clear flag, then clear and new timeout together.
    ClearTimeout = 1'b1;
    cycle();
    chk("r037_clear", {1'b0, TimeoutFlag}, 2'b00);
    ClearTimeout = 1'b0;
    Req = 2'b00;
    cycle();
    Req = 2'b10;
    n = 0;
    while (Grant !== 2'b10 && n < 10) begin
      cycle();
      n++;
    end
    chk("r037_regrant", Grant, 2'b10);
    ClearTimeout = 1'b1;
    n = 0;
    while (Abort === 2'b00 && n < 40) begin
      cycle();
      n++;
    end
    chk("r037_setwins", {1'b0, TimeoutFlag}, 2'b01);
    cycle();
    chk("r037_after", {1'b0, TimeoutFlag}, 2'b00);
    ClearTimeout = 1'b0;

    // Request drop on the very cycle the timeout fires.
    Req = 2'b00;
    repeat (4) cycle();
    Req = 2'b01;
    cycle();
    chk("r030_grant", Grant, 2'b01);
    repeat (TO - 1) cycle();
    Req = 2'b00;
    cycle();
    chk("r030_abort", Abort, 2'b01);
    chk("r030_flag", {1'b0, TimeoutFlag}, 2'b01);

    // Reset pulse while requester 0 holds the bus.
    repeat (4) cycle();
    Req = 2'b01; InClkRunning = 2'b01; InnSel = 2'b00;
    cycle();
    cycle();
    chk("r038_pre", Grant, 2'b01);
    mid_reset();

    // Randomized traffic in phases of differing clock activity.
    Req = 2'b00;
    for (int blk = 0; blk < 60; blk++) begin
      mode = int'($urandom_range(0, 2));
      for (int k = 0; k < 50; k++) begin
        if ($urandom_range(0, 7) == 0) Req[0] = ~Req[0];
        if ($urandom_range(0, 7) == 0) Req[1] = ~Req[1];
        InClkRunning = (mode == 0) ? 2'($urandom) : (mode == 1) ? 2'b00 : 2'b11;
        InClkStretch = 2'($urandom);
        InSPIDo      = 2'($urandom);
        InnSel       = 2'($urandom);
        ClearTimeout = ($urandom_range(0, 15) == 0);
        cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
